// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: buffers {j,k} commands with a repeat length and plays each one out as a run
// of registered j/k drive cycles. It also keeps q_model, a cycle-exact shadow of the
// downstream JK flip-flop output.
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   cmd_valid   command present on cmd_op/cmd_len
//   cmd_ready   FIFO not full
//   cmd_op      {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   cmd_len     drive cycles; 0 discards the command (done still pulses)
//   abort       synchronous flush, highest priority
//   j, k        registered drive to the downstream JK stage
//   q_model     expected downstream q
//   busy        driving, or commands buffered
//   done        one-cycle pulse at the end of each command
//   fifo_count  number of buffered commands
module jk_cmd_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CW-1:0]            cmd_len,
  input  logic                     abort,
  output logic                     j,
  output logic                     k,
  output logic                     q_model,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [1:0]      jk_q, jk_d;
  logic            done_q, done_d;
  logic            q_q, q_d;

  logic [1:0]      op_mem  [DEPTH];
  logic [CW-1:0]   len_mem [DEPTH];

  logic            push, pop, fifo_empty;
  logic [1:0]      head_op;
  logic [CW-1:0]   head_len;

  // Extra pointer MSB separates full from empty.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign cmd_ready  = (fifo_count != FullCount);
  assign push       = cmd_valid && cmd_ready && !abort;
  assign head_op    = op_mem[rd_ptr_q[AW-1:0]];
  assign head_len   = len_mem[rd_ptr_q[AW-1:0]];

  assign j       = jk_q[1];
  assign k       = jk_q[0];
  assign q_model = q_q;
  assign done    = done_q;
  assign busy    = (state_q == StDrive) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    jk_d    = jk_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: pop = !fifo_empty;
      StDrive: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CW'(1);
        end else begin
          // Last drive cycle: finish, and chain the next command with no bubble.
          done_d  = 1'b1;
          jk_d    = 2'b00;
          state_d = StIdle;
          pop     = !fifo_empty;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      if (head_len != '0) begin
        jk_d    = head_op;
        rem_d   = head_len - CW'(1);
        state_d = StDrive;
      end else begin
        jk_d    = 2'b00;
        rem_d   = '0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end

    if (abort) begin
      state_d = StIdle;
      rem_d   = '0;
      jk_d    = 2'b00;
      done_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Shadow of the downstream flip-flop; abort leaves it running.
  always_comb begin
    q_d = q_q;
    unique case (jk_q)
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      jk_q     <= 2'b00;
      done_q   <= 1'b0;
      q_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      jk_q     <= jk_d;
      done_q   <= done_d;
      q_q      <= q_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q[AW-1:0]]  <= cmd_op;
      len_mem[wr_ptr_q[AW-1:0]] <= cmd_len;
    end
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: a queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_jk_cmd_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       abort = 1'b0;
  logic       j, k, q_model, busy, done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  jk_cmd_seq #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .j          (j),
    .k          (k),
    .q_model    (q_model),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: pending commands, plus the remaining drive values of the current one.
  logic [1:0] q_op[$];
  logic [3:0] q_len[$];
  logic [1:0] play[$];
  logic [1:0] m_jk;
  logic       m_q, m_done, m_active;
  logic       m_rdy;
  logic [1:0] m_op;
  logic [3:0] m_len;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_op.delete(); q_len.delete(); play.delete();
      m_jk = 2'b00; m_q = 1'b0; m_done = 1'b0; m_active = 1'b0;
    end else begin
      m_rdy = (q_op.size() != DEPTH);
      case (m_jk)
        2'b01:   m_q = 1'b0;
        2'b10:   m_q = 1'b1;
        2'b11:   m_q = ~m_q;
        default: ;
      endcase
      if (abort) begin
        q_op.delete(); q_len.delete(); play.delete();
        m_jk = 2'b00; m_done = 1'b0; m_active = 1'b0;
      end else begin
        if (play.size() != 0) begin
          m_jk   = play.pop_front();
          m_done = 1'b0;
        end else begin
          m_done   = m_active;
          m_jk     = 2'b00;
          m_active = 1'b0;
          if (q_op.size() != 0) begin
            m_op  = q_op.pop_front();
            m_len = q_len.pop_front();
            if (m_len == 4'd0) begin
              m_done = 1'b1;
            end else begin
              m_jk     = m_op;
              m_active = 1'b1;
              for (int i = 1; i < int'(m_len); i++) play.push_back(m_op);
            end
          end
        end
        if (cmd_valid && m_rdy) begin
          q_op.push_back(cmd_op);
          q_len.push_back(cmd_len);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_j",     8'(j),          8'(m_jk[1]));
      chk("model_k",     8'(k),          8'(m_jk[0]));
      chk("model_q",     8'(q_model),    8'(m_q));
      chk("model_done",  8'(done),       8'(m_done));
      chk("model_busy",  8'(busy),       8'(m_active || (q_op.size() != 0)));
      chk("model_count", 8'(fifo_count), 8'(q_op.size()));
      chk("model_ready", 8'(cmd_ready),  8'(q_op.size() != DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds cmd_valid until accepted or the budget runs out; returns not-ready cycles waited.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] len, input int budget,
                          output int waited);
    bit ok = 1'b0;
    waited = 0;
    cmd_op = op;
    cmd_len = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else waited++;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: got not accepted, want accepted within %0d cycles", budget);
    end
  endtask

  int w;
  int nd;

  initial begin
    // Reset
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_j", 8'(j), 8'd0);
    chk("rst_k", 8'(k), 8'd0);
    chk("rst_q", 8'(q_model), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_count", 8'(fifo_count), 8'd0);
    chk("rst_ready", 8'(cmd_ready), 8'd1);

    // Single set, len 3
    push_cmd(2'b10, 4'd3, 4, w);
    chk("set_e0_j", 8'(j), 8'd0);
    chk("set_e0_count", 8'(fifo_count), 8'd1);
    tick();
    chk("set_e1_jk", 8'({j, k}), 8'b10);
    chk("set_e1_q", 8'(q_model), 8'd0);
    tick();
    chk("set_e2_q", 8'(q_model), 8'd1);
    tick();
    chk("set_e3_jk", 8'({j, k}), 8'b10);
    chk("set_e3_done", 8'(done), 8'd0);
    tick();
    chk("set_e4_jk", 8'({j, k}), 8'b00);
    chk("set_e4_done", 8'(done), 8'd1);
    tick();
    chk("set_e5_done", 8'(done), 8'd0);

    // Toggle len 4, then clear len 1
    push_cmd(2'b11, 4'd4, 4, w);
    push_cmd(2'b01, 4'd1, 4, w);
    chk("tog_a1_jk", 8'({j, k}), 8'b11);
    chk("tog_a1_q", 8'(q_model), 8'd1);
    tick();
    chk("tog_a2_q", 8'(q_model), 8'd0);
    tick();
    chk("tog_a3_q", 8'(q_model), 8'd1);
    tick();
    chk("tog_a4_q", 8'(q_model), 8'd0);
    tick();
    chk("tog_a5_jk", 8'({j, k}), 8'b01);
    chk("tog_a5_done", 8'(done), 8'd1);
    tick();
    chk("tog_a6_jk", 8'({j, k}), 8'b00);
    chk("tog_a6_q", 8'(q_model), 8'd0);
    chk("tog_a6_done", 8'(done), 8'd1);
    tick();
    chk("tog_a7_done", 8'(done), 8'd0);
    chk("tog_a7_q", 8'(q_model), 8'd0);

    // FIFO full behind a long running command
    push_cmd(2'b10, 4'd15, 4, w);
    push_cmd(2'b11, 4'd2, 4, w);
    push_cmd(2'b01, 4'd2, 4, w);
    push_cmd(2'b10, 4'd2, 4, w);
    push_cmd(2'b00, 4'd2, 4, w);
    chk("full_count", 8'(fifo_count), 8'd4);
    chk("full_ready", 8'(cmd_ready), 8'd0);
    push_cmd(2'b11, 4'd2, 40, w);
    chk("full_holdoff", 8'(w), 8'd12);
    repeat (14) tick();
    chk("full_drained", 8'(busy), 8'd0);

    // Abort mid-run with two commands queued
    push_cmd(2'b10, 4'd6, 4, w);
    push_cmd(2'b11, 4'd2, 4, w);
    push_cmd(2'b01, 4'd3, 4, w);
    chk("abort_pre_count", 8'(fifo_count), 8'd2);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_len = 4'd5;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_jk", 8'({j, k}), 8'b00);
    chk("abort_count", 8'(fifo_count), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_q_kept", 8'(q_model), 8'd1);
    nd = 0;
    repeat (8) begin
      if (done) nd++;
      tick();
    end
    chk("abort_no_done", 8'(nd), 8'd0);

    // Zero-length command
    push_cmd(2'b11, 4'd0, 4, w);
    nd = 0;
    repeat (4) begin
      if (done) nd++;
      if (j || k) nd += 16;
      tick();
    end
    chk("zero_len_done_once", 8'(nd), 8'd1);

    // Async reset mid-drive
    push_cmd(2'b10, 4'd8, 4, w);
    tick();
    tick();
    chk("pre_reset_j", 8'(j), 8'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_jk", 8'({j, k}), 8'b00);
    chk("async_rst_count", 8'(fifo_count), 8'd0);
    chk("async_rst_q", 8'(q_model), 8'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 8'(busy), 8'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
# jk_cmd_seq

Command sequencer that sits directly upstream of the JK flip-flop stage and drives its `j`/`k` inputs. It accepts hold/clear/set/toggle commands with a repeat length over a valid/ready handshake and buffers them in a small FIFO. It then plays each command out as a run of registered `j`/`k` cycles. It also keeps `q_model`, a cycle-exact shadow of the downstream flip-flop output, for checking and observability.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of 2, ≥2.
- `CW`, default 4: width of the command length field.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is synchronous to `clk`.
- `cmd_valid`  in  1  command present on `cmd_op`/`cmd_len`.
- `cmd_ready`  out  1  FIFO not full; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  operation: 00 hold, 01 clear, 10 set, 11 toggle. The encoding is `{j,k}`.
- `cmd_len`  in  CW  number of drive cycles; 0 means discard the command.
- `abort`  in  1  synchronous flush; takes priority over all other activity.
- `j`, `k`  out  1 each  registered drive to the downstream JK stage.
- `q_model`  out  1  expected downstream `q`.
- `busy`  out  1  state is DRIVE or the FIFO is non-empty.
- `done`  out  1  one-cycle pulse at the end of each command.
- `fifo_count`  out  $clog2(DEPTH)+1  number of buffered commands.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers one bit wider than the address, which distinguishes full from empty.
  - `cmd_ready = (fifo_count != DEPTH)`, combinational from the registered count.
  - A push on a full FIFO cannot occur, because `cmd_ready` is low.
  - A pop in the same cycle does not raise `cmd_ready`.
- **Simultaneous push and pop:** `fifo_count` is unchanged and both pointers advance.
- **FSM states:** IDLE, DRIVE.
  - IDLE with the FIFO non-empty: pop the head. If `len≠0`, load `{j,k}=op` and `remaining=len-1`, then go to DRIVE. If `len==0`, keep `{j,k}=00`, pulse `done` next cycle and stay in IDLE.
  - DRIVE with `remaining≠0`: decrement `remaining` and hold `j`/`k`.
  - DRIVE with `remaining==0` (last drive cycle): pulse `done` on the next cycle.
    - If the FIFO is non-empty, pop the next command back-to-back with no bubble and apply the IDLE rules to it.
    - If the FIFO is empty, set `{j,k}=00` and go to IDLE.
- **`q_model`:** updates on every edge using the JK truth table applied to the current `j`/`k`: 00 hold, 01 → 0, 10 → 1, 11 → invert.
- **`abort`:** on the next edge:
  - Both FIFO pointers are zeroed, so `fifo_count=0`.
  - `{j,k}=00`, state is IDLE, `remaining=0`, and `done=0`.
  - `q_model` is kept.
  - Any `cmd_valid` in the abort cycle is dropped.
- **Reset values:** `j=0`, `k=0`, `q_model=0`, `done=0`, `busy=0`, `fifo_count=0`, `cmd_ready=1`, state IDLE.
- **Reset mid-command:** the command in flight and all buffered commands are lost.
- **Bench alignment:** the downstream flip-flop must be cleared at the same time as this block, or the bench must resynchronise `q_model`.

## Timing
- **Acceptance to first drive:** a command accepted at edge N with the block idle has `j`/`k` driven from edge N+1. There is no FIFO bypass.
- **Drive duration:** each command drives exactly `len` consecutive cycles.
- **Back-to-back commands:** consecutive buffered commands drive with zero gap cycles.
- **`done`:** high for exactly one cycle, starting at the edge that ends the last drive cycle. A `len=0` command raises `done` one cycle after its pop.
- **`q_model`:** changes one edge after the `j`/`k` value that causes it, matching the downstream flip-flop sampling the same edge.
- **Throughput:** one command per cycle is accepted while the FIFO is not full.

## Test plan
- **Reset:** hold reset low for 3 cycles, then release.
  - Required: all outputs at their reset values, including `cmd_ready=1` and `fifo_count=0`.
- **Single set command:** push op=10, len=3 at edge 0.
  - Required: `j=1,k=0` during cycles 1–3, then 00.
  - Required: `done` high in cycle 4 only; `q_model` 0→1 after edge 2.
- **Toggle followed by clear:** push op=11 len=4, then op=01 len=1.
  - Required: `q_model` sequence 1,0,1,0, then `j`/`k`=01 with no bubble, then `q_model` stays 0.
  - Required: `done` pulses twice.
- **FIFO full:** with `DEPTH=4` and a long first command, push 5 commands.
  - Required: `fifo_count` reaches 4 and `cmd_ready=0`.
  - Required: the 5th command is held off until the first pop; all 5 execute in order.
- **Abort mid-run:** abort during cycle 2 of a len=6 command with 2 commands queued.
  - Required: next cycle `j`=`k`=0, `fifo_count=0`, `done` never pulses, `busy=0`.
- **Zero-length and async reset:** push len=0.
  - Required: no drive cycles and `done` pulses once.
  - Then assert reset mid-DRIVE. Required: `j`/`k` fall to 0 immediately, without waiting for a clock edge.
